// File: rtl/vpifo_pkg.sv
// Shared types and width helpers for the virtual-PIFO tree scheduler.
package vpifo_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   function automatic int tb_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int cw_width(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/vpifo_sync_fifo.sv
// Small synchronous FIFO holding popped {data, tree id} entries in issue order.
module vpifo_sync_fifo
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNTW = $clog2(DEPTH + 1)
)(
   input  logic             i_clk,
   input  logic             i_arst_n,
   input  logic             i_wr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_rd,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_empty,
   output logic [CNTW-1:0]  o_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CNTW-1:0]  r_count;
   logic             w_rd;
   logic             w_wr;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   // A write into a full buffer is accepted when the head leaves in the same cycle
   assign w_rd    = i_rd && (r_count != '0);
   assign w_wr    = i_wr && ((r_count != CNTW'(DEPTH)) || w_rd);
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_rdata = (r_count == '0) ? '0 : r_mem[r_rptr];

   // Pointer and occupancy bookkeeping
   always_ff @(posedge i_clk) begin
      if (!i_arst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_wr) r_wptr <= ptr_inc(r_wptr);
         if (w_rd) r_rptr <= ptr_inc(r_rptr);
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + CNTW'(1);
            2'b01:   r_count <= r_count - CNTW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry storage; contents are don't-care while empty
   always_ff @(posedge i_clk) begin
      if (w_wr) r_mem[r_wptr] <= i_wdata;
   end

endmodule

// File: rtl/vpifo_tree_sched.sv
// Schedules pushes and round-robin pops of several virtual trees over one PIFO lane,
// with credit-limited pop issue and an in-order output buffer.
module vpifo_tree_sched
   import vpifo_pkg::*;
#(
   parameter int PTW       = 16,
   parameter int TREE_NUM  = 4,
   parameter int FIFO_SIZE = 2048,
   parameter int POP_LAT   = 2,
   localparam int TB       = tb_width(TREE_NUM),
   localparam int CW       = cw_width(FIFO_SIZE)
)(
   input  logic                   i_clk,
   input  logic                   i_arst_n,
   input  logic                   i_en,
   input  logic [TREE_NUM-1:0]    i_tree_en,
   input  logic                   i_push,
   input  logic [TB-1:0]          i_push_tree_id,
   input  logic [PTW-1:0]         i_push_data,
   output logic                   o_push_ready,
   output logic                   o_push,
   output logic [TB-1:0]          o_push_tree_id,
   output logic [PTW-1:0]         o_push_data,
   output logic                   o_pop,
   output logic [TB-1:0]          o_pop_tree_id,
   input  logic [PTW-1:0]         i_pop_data,
   input  logic                   i_task_fifo_full,
   output logic                   o_deq_valid,
   output logic [PTW-1:0]         o_deq_data,
   output logic [TB-1:0]          o_deq_tree_id,
   input  logic                   i_deq_ready,
   output logic [TREE_NUM*CW-1:0] o_occ,
   output logic [1:0]             o_state
);

   localparam int DEPTH = POP_LAT + 2;
   localparam int BW    = PTW + TB;
   localparam int BCW   = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] OCC_MAX = CW'(FIFO_SIZE);

   state_t              r_state;
   state_t              w_next_state;
   logic [CW-1:0]       r_occ [TREE_NUM];
   logic [TB-1:0]       r_rr_ptr;
   logic                r_push;
   logic [TB-1:0]       r_push_tree_id;
   logic [PTW-1:0]      r_push_data;
   logic                r_pop;
   logic [TB-1:0]       r_pop_tree_id;
   logic [POP_LAT-1:0]  r_pv;
   logic [TB-1:0]       r_pid [POP_LAT];
   logic                w_push_acc;
   logic                w_issue;
   logic                w_found;
   logic                w_credit;
   logic                w_any_occ;
   logic                w_drained;
   logic                w_deq;
   logic                w_buf_empty;
   logic [TB-1:0]       w_sel;
   logic [TREE_NUM-1:0] w_elig;
   logic [TREE_NUM-1:0] w_inc;
   logic [TREE_NUM-1:0] w_dec;
   logic [BCW-1:0]      w_buf_count;
   logic [BW-1:0]       w_buf_rdata;
   int                  w_inflight;

   assign o_push_ready = (r_state == ST_RUN) && !i_task_fifo_full &&
                         (r_occ[i_push_tree_id] < OCC_MAX);
   assign w_push_acc   = i_push && o_push_ready;

   // Per-tree pop eligibility; the enable mask only applies while running
   always_comb begin
      w_any_occ = 1'b0;
      for (int t = 0; t < TREE_NUM; t++) begin
         w_elig[t] = (r_occ[t] != '0) &&
                     ((r_state == ST_DRAIN) || ((r_state == ST_RUN) && i_tree_en[t]));
         w_any_occ = w_any_occ | (r_occ[t] != '0);
      end
   end

   // Round-robin pick among eligible trees, starting at the pointer
   always_comb begin
      int   idx;
      logic hit;
      idx     = 0;
      hit     = 1'b0;
      w_found = 1'b0;
      w_sel   = '0;
      for (int i = 0; i < TREE_NUM; i++) begin
         idx     = int'(r_rr_ptr) + i;
         idx     = (idx >= TREE_NUM) ? idx - TREE_NUM : idx;
         hit     = !w_found && w_elig[TB'(idx)];
         w_sel   = hit ? TB'(idx) : w_sel;
         w_found = w_found | hit;
      end
   end

   // Credit counts only registered state, so a dequeue this cycle frees nothing yet
   always_comb begin
      w_inflight = int'(r_pop);
      for (int k = 0; k < POP_LAT; k++) begin
         w_inflight = w_inflight + int'(r_pv[k]);
      end
   end

   assign w_credit = (int'(w_buf_count) + w_inflight) < DEPTH;
   assign w_issue  = w_found && w_credit && !i_task_fifo_full;

   // Per-tree occupancy deltas
   always_comb begin
      for (int t = 0; t < TREE_NUM; t++) begin
         w_inc[t] = w_push_acc && (i_push_tree_id == TB'(t));
         w_dec[t] = w_issue && (w_sel == TB'(t));
      end
   end

   assign w_drained = !w_any_occ && !r_pop && (r_pv == '0) && w_buf_empty;

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (i_en) w_next_state = ST_RUN;
            else      w_next_state = ST_IDLE;
         end
         ST_RUN: begin
            if (!i_en) w_next_state = ST_DRAIN;
            else       w_next_state = ST_RUN;
         end
         ST_DRAIN: begin
            if (i_en)           w_next_state = ST_RUN;
            else if (w_drained) w_next_state = ST_IDLE;
            else                w_next_state = ST_DRAIN;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // State, push lane, pop issue and round-robin pointer
   always_ff @(posedge i_clk) begin
      if (!i_arst_n) begin
         r_state        <= ST_IDLE;
         r_push         <= 1'b0;
         r_push_tree_id <= '0;
         r_push_data    <= '0;
         r_pop          <= 1'b0;
         r_pop_tree_id  <= '0;
         r_rr_ptr       <= '0;
      end else begin
         r_state <= w_next_state;
         r_push  <= w_push_acc;
         r_pop   <= w_issue;
         if (w_push_acc) begin
            r_push_tree_id <= i_push_tree_id;
            r_push_data    <= i_push_data;
         end
         if (w_issue) begin
            r_pop_tree_id <= w_sel;
            r_rr_ptr      <= (w_sel == TB'(TREE_NUM - 1)) ? '0 : w_sel + TB'(1);
         end
      end
   end

   // Occupancy counters; a push and pop on the same tree cancel out
   always_ff @(posedge i_clk) begin
      for (int t = 0; t < TREE_NUM; t++) begin
         if (!i_arst_n)                 r_occ[t] <= '0;
         else if (w_inc[t] && !w_dec[t]) r_occ[t] <= r_occ[t] + CW'(1);
         else if (w_dec[t] && !w_inc[t]) r_occ[t] <= r_occ[t] - CW'(1);
         else                           r_occ[t] <= r_occ[t];
      end
   end

   // Tree id follows each pop until the PIFO returns its data
   always_ff @(posedge i_clk) begin
      if (!i_arst_n) begin
         r_pv <= '0;
         for (int k = 0; k < POP_LAT; k++) r_pid[k] <= '0;
      end else begin
         r_pv[0]  <= r_pop;
         r_pid[0] <= r_pop_tree_id;
         for (int k = 1; k < POP_LAT; k++) begin
            r_pv[k]  <= r_pv[k-1];
            r_pid[k] <= r_pid[k-1];
         end
      end
   end

   assign w_deq = !w_buf_empty && i_deq_ready;

   vpifo_sync_fifo #(
      .WIDTH (BW),
      .DEPTH (DEPTH)
   ) u_out_buf (
      .i_clk    (i_clk),
      .i_arst_n (i_arst_n),
      .i_wr     (r_pv[POP_LAT-1]),
      .i_wdata  ({i_pop_data, r_pid[POP_LAT-1]}),
      .i_rd     (w_deq),
      .o_rdata  (w_buf_rdata),
      .o_empty  (w_buf_empty),
      .o_count  (w_buf_count)
   );

   assign o_push         = r_push;
   assign o_push_tree_id = r_push_tree_id;
   assign o_push_data    = r_push_data;
   assign o_pop          = r_pop;
   assign o_pop_tree_id  = r_pop_tree_id;
   assign o_deq_valid    = !w_buf_empty;
   assign o_deq_data     = w_buf_rdata[BW-1 -: PTW];
   assign o_deq_tree_id  = w_buf_rdata[TB-1:0];
   assign o_state        = r_state;

   for (genvar g = 0; g < TREE_NUM; g++) begin : g_occ
      assign o_occ[g*CW +: CW] = r_occ[g];
   end

endmodule
